// File: rtl/fw_collector_pkg.sv
// Shared constants and types for the FW result collector: array geometry,
// instruction op codes, memory address width and collector FSM states.
package fw_collector_pkg;

  // PE array geometry: L lanes of WIDTH bits per result word, B x B tile.
  localparam int L      = 4;
  localparam int WIDTH  = 8;
  localparam int B      = 8;
  localparam int DATA_W = L * WIDTH;

  // Instruction word layout; only the low OP_WIDTH bits carry the op code.
  localparam int INSTR_WIDTH = 16;
  localparam int OP_WIDTH    = 3;

  // Tile memory write-address width.
  localparam int ADDR_WIDTH = 8;

  // Default number of result words produced per tile.
  localparam int TILE_WORDS_DEF = (B * B) / L;

  // Op codes seen on the last PE's instruction output.
  localparam logic [OP_WIDTH-1:0] OP_IDLE    = 3'd0;
  localparam logic [OP_WIDTH-1:0] OP_COMPUTE = 3'd1;
  localparam logic [OP_WIDTH-1:0] OP_FORWARD = 3'd2;
  localparam logic [OP_WIDTH-1:0] OP_LOAD    = 3'd3;

  // Collector control states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  // Only COMPUTE and FORWARD cycles carry a result worth storing.
  function automatic logic is_result_op(input logic [OP_WIDTH-1:0] op);
    return (op == OP_COMPUTE) || (op == OP_FORWARD);
  endfunction

endpackage

// File: rtl/fw_fifo.sv
// Small show-ahead FIFO: the head entry is visible on dout whenever the FIFO
// is not empty. A push into a full FIFO is accepted only if a pop happens in
// the same cycle; a pop while empty does nothing.
module fw_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head word read straight from the storage array for zero-latency show-ahead.
  assign dout = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // One register per entry; cleared on reset so dout reads zero afterwards.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mem_q[gi] <= '0;
      end else if (do_push && (wr_ptr_q == PW'(gi))) begin
        mem_q[gi] <= din;
      end
    end
  end

endmodule

// File: rtl/fw_collector.sv
// Tail collector of the FW PE array. Buffers result words from the last PE,
// writes them to tile memory at sequential addresses from a programmed base,
// pulses done after one tile and keeps a sticky flag for dropped words.
module fw_collector
  import fw_collector_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int TILE_WORDS = TILE_WORDS_DEF,
  parameter int MEM_AW     = ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      in,
  input  logic                   in_valid,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic                   start,
  input  logic [MEM_AW-1:0]      base_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic [MEM_AW-1:0]      wr_addr,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int CW = $clog2(TILE_WORDS + 1);
  localparam int OW = $clog2(DEPTH + 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       push_cnt_q, push_cnt_d;
  logic [CW-1:0]       wr_cnt_q, wr_cnt_d;
  logic [OW-1:0]       occ_q, occ_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic                ovf_q, ovf_d;
  logic                busy_q;
  logic                done_q;

  logic                fifo_empty;
  logic                fifo_full;
  logic [DATA_W-1:0]   fifo_dout;
  logic [OP_WIDTH-1:0] op;
  logic                want_push;
  logic                accept;
  logic                drop;
  logic                pop;
  logic                unused_instr_bits;

  // Only the op field of the forwarded instruction matters here.
  assign op                = instr_in[OP_WIDTH-1:0];
  assign unused_instr_bits = ^instr_in[INSTR_WIDTH-1:OP_WIDTH];

  // The write port presents the FIFO head directly while a tile is active.
  assign wr_valid = (state_q == S_ACTIVE) && !fifo_empty;
  assign wr_data  = fifo_dout;
  assign pop      = wr_valid && wr_ready;

  // A word is wanted until a full tile has been seen; when the FIFO is full it
  // still fits only if the head leaves in the same cycle, else it is lost.
  assign want_push = (state_q == S_ACTIVE) && in_valid && is_result_op(op) &&
                     (push_cnt_q < CW'(TILE_WORDS));
  assign accept    = want_push && (!fifo_full || pop);
  assign drop      = want_push && !accept;

  assign wr_addr  = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

  fw_fifo #(
    .DEPTH (DEPTH),
    .DW    (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (pop),
    .din   (in),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Next-state logic for the FSM, counters, write address and overflow flag.
  always_comb begin
    state_d    = state_q;
    push_cnt_d = push_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    addr_d     = addr_q;
    ovf_d      = ovf_q;
    occ_d      = occ_q;

    if (accept && !pop) begin
      occ_d = occ_q + OW'(1);
    end else if (!accept && pop) begin
      occ_d = occ_q - OW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ACTIVE;
          addr_d     = base_addr;
          push_cnt_d = '0;
          wr_cnt_d   = '0;
          ovf_d      = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (want_push) begin
          push_cnt_d = push_cnt_q + CW'(1);
        end
        if (pop) begin
          wr_cnt_d = wr_cnt_q + CW'(1);
          addr_d   = addr_q + MEM_AW'(1);
        end
        if (drop) begin
          ovf_d = 1'b1;
        end
        // Dropped words never get written, so a tile also ends once every
        // word has been seen and the buffer has drained.
        if ((wr_cnt_d == CW'(TILE_WORDS)) ||
            ((push_cnt_d == CW'(TILE_WORDS)) && (occ_d == '0))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter and status registers; status outputs follow the next state
  // so busy/done line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      push_cnt_q <= '0;
      wr_cnt_q   <= '0;
      occ_q      <= '0;
      addr_q     <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      push_cnt_q <= push_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      occ_q      <= occ_d;
      addr_q     <= addr_d;
      ovf_q      <= ovf_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_fw_collector.sv
// Directed bench for fw_collector with a write scoreboard: every word that
// should reach memory is queued with its address when driven, and popped and
// compared when the write port completes a transfer.
module tb_fw_collector;
  import fw_collector_pkg::*;

  localparam int TW = 8;
  localparam int DP = 4;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_W;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [DW-1:0]          in_w;
  logic                   in_valid;
  logic [INSTR_WIDTH-1:0] instr_w;
  logic                   start;
  logic [AW-1:0]          base_addr;
  logic [DW-1:0]          wr_data;
  logic [AW-1:0]          wr_addr;
  logic                   wr_valid;
  logic                   wr_ready;
  logic                   busy;
  logic                   done;
  logic                   overflow;

  always #5 clk = ~clk;

  fw_collector #(
    .DEPTH      (DP),
    .TILE_WORDS (TW),
    .MEM_AW     (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_w),
    .in_valid  (in_valid),
    .instr_in  (instr_w),
    .start     (start),
    .base_addr (base_addr),
    .wr_data   (wr_data),
    .wr_addr   (wr_addr),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cap;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            checks   = 0;
  int            errors   = 0;
  int            cyc      = 0;
  int            wr_cnt   = 0;
  int            done_cnt = 0;
  bit            strict   = 1'b0;
  logic [AW-1:0] addr_model;

  // Filtering stimulus: valid flag and op per cycle.
  bit          f_v  [14] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
  int unsigned f_op [14] = '{1, 0, 2, 1, 1, 3, 2, 2, 1, 0, 2, 1, 2, 1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int k);
    return DW'(32'h01010101 * k);
  endfunction

  always @(posedge clk) cyc++;

  // Write-port monitor: scoreboard compare on each completed transfer.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      chk("busy_in_done", busy, 1'b1);
    end
    if (wr_valid && wr_ready) begin
      wr_cnt++;
      chk("write_expected", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("wr_addr", wr_addr, mon_e.addr);
        chk("wr_data", wr_data, mon_e.data);
        if (strict) chk("latency_cycle", cyc, mon_e.cap);
        $display("write #%0d addr=%0h data=%0h cyc=%0d", wr_cnt, wr_addr, wr_data, cyc);
      end
    end
  end

  // One input cycle; words expected at memory are queued with their address.
  task automatic drive(input logic [DW-1:0] d, input logic [OP_WIDTH-1:0] op,
                       input logic v, input logic rdy, input logic expect_wr);
    @(posedge clk);
    #1;
    in_w     = d;
    instr_w  = {{(INSTR_WIDTH-OP_WIDTH){1'b1}}, op};
    in_valid = v;
    wr_ready = rdy;
    if (expect_wr) begin
      sb.push_back('{addr: addr_model, data: d, cap: cyc + 1});
      addr_model = addr_model + AW'(1);
    end
  endtask

  task automatic start_tile(input logic [AW-1:0] b);
    @(posedge clk);
    #1;
    done_cnt   = 0;
    wr_cnt     = 0;
    in_valid   = 1'b0;
    start      = 1'b1;
    base_addr  = b;
    addr_model = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n_writes);
    for (int i = 0; i < 64 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2;
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_write_count"}, wr_cnt, n_writes);
    chk({tag, "_sb_drained"}, sb.size(), 0);
    chk({tag, "_idle_after"}, busy, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    in_w      = '0;
    in_valid  = 1'b0;
    instr_w   = '0;
    wr_ready  = 1'b0;
    addr_model = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_wr_data", wr_data, '0);
    chk("rst_wr_addr", wr_addr, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    reset = 1'b0;

    // Streaming at full rate.
    strict = 1'b1;
    start_tile(8'h10);
    chk("busy_rise", busy, 1'b1);
    for (int k = 1; k <= 8; k++) drive(word(k), OP_COMPUTE, 1'b1, 1'b1, 1'b1);
    drive('0, OP_IDLE, 1'b0, 1'b1, 1'b0);
    wait_done("stream", 8);
    chk("stream_overflow", overflow, 1'b0);
    strict = 1'b0;

    // Backpressure for the first three cycles.
    start_tile(8'h10);
    for (int k = 0; k < 8; k++) begin
      drive(word(k + 1), OP_COMPUTE, 1'b1, (k >= 3), 1'b1);
      #1;
      if (k >= 1 && k <= 3) begin
        chk("bp_hold_valid", wr_valid, 1'b1);
        chk("bp_hold_data", wr_data, word(1));
        chk("bp_hold_addr", wr_addr, 8'h10);
      end
      if (k == 3) chk("bp_fifo_level", dut.occ_q, 3);
    end
    drive('0, OP_IDLE, 1'b0, 1'b1, 1'b0);
    wait_done("backpressure", 8);
    chk("bp_overflow", overflow, 1'b0);

    // Overflow: memory stalled for the whole input burst.
    start_tile(8'h10);
    for (int k = 0; k < 8; k++) begin
      drive(word(k + 1), OP_COMPUTE, 1'b1, 1'b0, (k < 4));
      #1;
      if (k == 4) begin
        chk("ovf_fifo_full", dut.occ_q, 4);
        chk("ovf_not_yet", overflow, 1'b0);
      end
      if (k == 5) chk("ovf_set", overflow, 1'b1);
    end
    drive('0, OP_IDLE, 1'b0, 1'b1, 1'b0);
    wait_done("overflow", 4);
    chk("ovf_sticky", overflow, 1'b1);

    // Filtering: words before start and non-result ops are discarded.
    for (int k = 0; k < 3; k++) drive(DW'(32'hEE000000 + k), OP_COMPUTE, 1'b1, 1'b1, 1'b0);
    start_tile(8'h30);
    chk("filter_ovf_cleared", overflow, 1'b0);
    begin
      int n;
      n = 0;
      for (int i = 0; i < 14; i++) begin
        logic exp_w;
        exp_w = f_v[i] && (f_op[i] == 1 || f_op[i] == 2) && (n < TW);
        if (exp_w) n++;
        drive(DW'(32'hC0000000 + i), OP_WIDTH'(f_op[i]), f_v[i], 1'b1, exp_w);
      end
    end
    drive('0, OP_IDLE, 1'b0, 1'b1, 1'b0);
    wait_done("filter", 8);

    // Address wrap through zero.
    strict = 1'b1;
    start_tile(8'hFD);
    for (int k = 1; k <= 8; k++) drive(DW'(32'h50000000 + k), OP_FORWARD, 1'b1, 1'b1, 1'b1);
    drive('0, OP_IDLE, 1'b0, 1'b1, 1'b0);
    wait_done("wrap", 8);
    strict = 1'b0;

    // Reset in the middle of a tile.
    start_tile(8'h40);
    for (int k = 1; k <= 4; k++) drive(word(k), OP_COMPUTE, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("mid_writes_before_reset", wr_cnt, 3);
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_valid", wr_valid, 1'b0);
    chk("mid_rst_wr_data", wr_data, '0);
    chk("mid_rst_wr_addr", wr_addr, '0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_overflow", overflow, 1'b0);
    sb.delete();
    drive(word(9), OP_COMPUTE, 1'b1, 1'b1, 1'b0);
    drive(word(10), OP_COMPUTE, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    for (int k = 11; k <= 14; k++) drive(word(k), OP_COMPUTE, 1'b1, 1'b1, 1'b0);
    drive('0, OP_IDLE, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    chk("mid_no_writes_after", wr_cnt, 3);
    chk("mid_idle_after", busy, 1'b0);

    // Normal tile after the reset.
    strict = 1'b1;
    start_tile(8'h20);
    for (int k = 1; k <= 8; k++) drive(DW'(32'h30000000 + k), OP_COMPUTE, 1'b1, 1'b1, 1'b1);
    drive('0, OP_IDLE, 1'b0, 1'b1, 1'b0);
    wait_done("restart", 8);
    chk("restart_overflow", overflow, 1'b0);
    strict = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
